// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control FSM for the RV64 datapath: latches the fetched
// instruction, decodes it and drives the datapath controls and a one-cycle commit window.
module unidade_controle_multiciclo #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      instrucao,
    output logic             load_en,
    output logic             store_en,
    output logic [1:0]       op_ula,
    output logic [1:0]       operation_type,
    output logic             ula_entry,
    output logic             branch,
    output logic             auipc,
    output logic             jal,
    output logic             jalr,
    output logic             sign,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] LP_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ir;
    logic [3:0]       r_cnt;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic       w_known;
    logic       w_sys;
    logic       w_mem;
    logic       w_ld;
    logic       w_st;
    logic [1:0] w_opt;
    logic       w_ue;
    logic [1:0] w_opu;
    logic       w_br;
    logic       w_au;
    logic       w_jal;
    logic       w_jalr;
    logic       w_sign;
    logic       w_last;
    logic       w_ctrl;
    logic       w_commit;
    logic       w_unused;

    // Only the opcode, funct3[2:1] and bit 30 steer the controls
    assign w_unused = ^{r_ir[31], r_ir[29:15], r_ir[12:7]};

    always_comb begin
        w_known = 1'b1;
        w_sys   = 1'b0;
        w_mem   = 1'b0;
        w_ld    = 1'b0;
        w_st    = 1'b0;
        w_opt   = 2'b00;
        w_ue    = 1'b0;
        w_opu   = 2'b00;
        w_br    = 1'b0;
        w_au    = 1'b0;
        w_jal   = 1'b0;
        w_jalr  = 1'b0;
        w_sign  = 1'b0;
        case (r_ir[6:0])
            OP_LOAD: begin
                w_mem = 1'b1;
                w_ld  = 1'b1;
                w_opt = 2'b01;
                w_opu = 2'b01;
            end
            OP_STORE: begin
                w_mem = 1'b1;
                w_st  = 1'b1;
                w_opt = 2'b01;
                w_opu = 2'b01;
            end
            OP_R: begin
                w_ld  = 1'b1;
                w_ue  = 1'b1;
                w_opu = r_ir[30] ? 2'b00 : 2'b01;
            end
            OP_I: begin
                w_ld  = 1'b1;
                w_opu = r_ir[30] ? 2'b00 : 2'b01;
            end
            OP_BR: begin
                w_opt = 2'b01;
                w_ue  = 1'b1;
                w_br  = 1'b1;
                case (r_ir[14:13])
                    2'b00: begin
                        w_opu  = 2'b10;
                        w_sign = 1'b1;
                    end
                    2'b10: begin
                        w_opu  = 2'b11;
                        w_sign = 1'b1;
                    end
                    2'b11: begin
                        w_opu  = 2'b11;
                        w_sign = 1'b0;
                    end
                    default: w_known = 1'b0;
                endcase
            end
            OP_JAL: begin
                w_ld  = 1'b1;
                w_opt = 2'b10;
                w_jal = 1'b1;
            end
            OP_JALR: begin
                w_ld   = 1'b1;
                w_opt  = 2'b10;
                w_jalr = 1'b1;
            end
            OP_AUIPC: begin
                w_ld  = 1'b1;
                w_opt = 2'b10;
                w_au  = 1'b1;
            end
            OP_SYS: begin
                w_known = 1'b0;
                w_sys   = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_last = (r_cnt == LP_LAST);
    assign w_ctrl = (r_state == S_EXEC) || (r_state == S_MEM);

    // A reset arriving in the commit cycle cancels the commit
    assign w_commit = !reset &&
        (((r_state == S_EXEC) && !w_mem) ||
         ((r_state == S_MEM) && w_last));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_sys || !w_known) w_next = S_HALT;
                else                   w_next = S_EXEC;
            end
            S_EXEC:   w_next = w_mem ? S_MEM : S_FETCH;
            S_MEM:    if (w_last) w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= instrucao;
            if ((r_state == S_MEM) && !w_last) r_cnt <= r_cnt + 4'd1;
            else                               r_cnt <= '0;
            if ((r_state == S_DECODE) && !w_known && !w_sys)
                r_illegal <= 1'b1;
            if (w_commit) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        pc_en          = w_commit;
        load_en        = w_commit & w_ld;
        store_en       = w_commit & w_st;
        op_ula         = w_ctrl ? w_opu : 2'b00;
        operation_type = w_ctrl ? w_opt : 2'b00;
        ula_entry      = w_ctrl & w_ue;
        branch         = w_ctrl & w_br;
        auipc          = w_ctrl & w_au;
        jal            = w_ctrl & w_jal;
        jalr           = w_ctrl & w_jalr;
        sign           = w_ctrl & w_sign;
        busy           = (r_state != S_IDLE) && (r_state != S_HALT);
        halted         = (r_state == S_HALT);
        illegal        = r_illegal;
        retired_count  = r_retired;
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: timeline reference model per
// instruction, directed scenarios and a randomized instruction stream.
module tb_unidade_controle_multiciclo;

    localparam int MW = 3;
    localparam int CW = 4;

    localparam logic [31:0] I_ADD   = 32'h01538FB3;
    localparam logic [31:0] I_LD    = 32'h0003B283;
    localparam logic [31:0] I_SD    = 32'h0053B023;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    typedef struct packed {
        logic       ld;
        logic       st;
        logic [1:0] opu;
        logic [1:0] opt;
        logic       ue;
        logic       br;
        logic       au;
        logic       jal;
        logic       jalr;
        logic       sign;
        logic       pc;
        logic       busy;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   instrucao;
    logic          load_en, store_en, ula_entry, branch, auipc;
    logic          jal, jalr, sign, pc_en, busy, halted, illegal;
    logic [1:0]    op_ula, operation_type;
    logic [CW-1:0] retired_count;
    obs_t          obs;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ret = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .instrucao(instrucao),
        .load_en(load_en), .store_en(store_en), .op_ula(op_ula),
        .operation_type(operation_type), .ula_entry(ula_entry),
        .branch(branch), .auipc(auipc), .jal(jal), .jalr(jalr),
        .sign(sign), .pc_en(pc_en), .busy(busy), .halted(halted),
        .illegal(illegal), .retired_count(retired_count)
    );

    assign obs = {load_en, store_en, op_ula, operation_type, ula_entry,
                  branch, auipc, jal, jalr, sign, pc_en, busy, halted,
                  illegal};

    // 0 plain op, 1 memory op, 2 halts as illegal, 3 halts cleanly
    function automatic int kind_of(input logic [31:0] ir);
        case (ir[6:0])
            7'b0000011, 7'b0100011: return 1;
            7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0010111: return 0;
            7'b1100011: return (ir[14:13] == 2'b01) ? 2 : 0;
            7'b1110011: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs in cycle cyc of an instruction (0 = fetch cycle)
    function automatic obs_t exp_vec(input logic [31:0] ir, input int cyc);
        obs_t e;
        int   k;
        int   len;
        logic c;
        e = '0;
        k = kind_of(ir);
        len = (k == 1) ? 3 + MW : 3;
        if (k >= 2) begin
            if (cyc < 2) e.busy = 1'b1;
            else begin
                e.halted  = 1'b1;
                e.illegal = (k == 2);
            end
            return e;
        end
        e.busy = 1'b1;
        if (cyc < 2) return e;
        c = (cyc == len - 1);
        e.pc = c;
        case (ir[6:0])
            7'b0000011: begin e.ld = c; e.opt = 2'd1; e.opu = 2'd1; end
            7'b0100011: begin e.st = c; e.opt = 2'd1; e.opu = 2'd1; end
            7'b0110011: begin
                e.ld = c; e.ue = 1'b1; e.opu = ir[30] ? 2'd0 : 2'd1;
            end
            7'b0010011: begin e.ld = c; e.opu = ir[30] ? 2'd0 : 2'd1; end
            7'b1100011: begin
                e.opt = 2'd1; e.ue = 1'b1; e.br = 1'b1;
                if (ir[14:13] == 2'b00) begin e.opu = 2'd2; e.sign = 1'b1; end
                else if (ir[14:13] == 2'b10) begin e.opu = 2'd3; e.sign = 1'b1; end
                else e.opu = 2'd3;
            end
            7'b1101111: begin e.ld = c; e.opt = 2'd2; e.jal = 1'b1; end
            7'b1100111: begin e.ld = c; e.opt = 2'd2; e.jalr = 1'b1; end
            default:    begin e.ld = c; e.opt = 2'd2; e.au = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic int len_of(input logic [31:0] ir);
        return (kind_of(ir) == 1) ? 3 + MW : 3;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  unk [4];
        int          s;
        unk = '{7'h00, 7'h7F, 7'h0F, 7'h37};
        r = $urandom;
        s = $urandom_range(0, 19);
        if (s < 2)       r[6:0] = 7'b0000011;
        else if (s < 4)  r[6:0] = 7'b0100011;
        else if (s < 7)  r[6:0] = 7'b0110011;
        else if (s < 10) r[6:0] = 7'b0010011;
        else if (s < 13) r[6:0] = 7'b1100011;
        else if (s == 13) r[6:0] = 7'b1101111;
        else if (s == 14) r[6:0] = 7'b1100111;
        else if (s == 15) r[6:0] = 7'b0010111;
        else if (s == 16) r[6:0] = unk[$urandom_range(0, 3)];
        else if (s == 17) r = I_ECALL;
        else r[6:0] = 7'b0010011;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        exp_ret = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        instrucao = $urandom;
        tick();
        tick();
        checks++;
        if (obs !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0000", obs);
        end
        checks++;
        if (retired_count !== '0) begin
            errors++;
            $display("FAIL reset_retired: got %0d want 0", retired_count);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (obs !== obs_t'(0)) begin
            errors++;
            $display("FAIL idle_hold: got %h want 0000", obs);
        end
    endtask

    task automatic test_add();
        start = 1'b1;
        instrucao = I_ADD;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== exp_vec(I_ADD, c)) begin
                errors++;
                $display("FAIL add_cyc%0d: got %h want %h", c, obs,
                         exp_vec(I_ADD, c));
            end
            if (c > 0) instrucao = $urandom;
            if (c == 2) begin
                checks++;
                if ({operation_type, ula_entry, op_ula, load_en, pc_en}
                    !== 7'b00_1_01_1_1) begin
                    errors++;
                    $display("FAIL add_exec: got %b want 0010111",
                             {operation_type, ula_entry, op_ula,
                              load_en, pc_en});
                end
            end
            tick();
        end
        exp_ret = 1;
        checks++;
        if (retired_count !== exp_ret[CW-1:0]) begin
            errors++;
            $display("FAIL add_retired: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_load();
        instrucao = I_LD;
        for (int c = 0; c < 3 + MW; c++) begin
            checks++;
            if (obs !== exp_vec(I_LD, c) || busy !== 1'b1 ||
                pc_en !== (c == 2 + MW)) begin
                errors++;
                $display("FAIL load_cyc%0d: got %h want %h", c, obs,
                         exp_vec(I_LD, c));
            end
            if (c > 0) instrucao = $urandom;
            tick();
        end
        exp_ret++;
        checks++;
        if (retired_count !== exp_ret[CW-1:0]) begin
            errors++;
            $display("FAIL load_retired: got %0d want %0d",
                     retired_count, exp_ret[CW-1:0]);
        end
    endtask

    task automatic test_bltu();
        instrucao = I_BLTU;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== exp_vec(I_BLTU, c)) begin
                errors++;
                $display("FAIL bltu_cyc%0d: got %h want %h", c, obs,
                         exp_vec(I_BLTU, c));
            end
            if (c == 2) begin
                checks++;
                if ({branch, op_ula, sign, store_en, load_en, pc_en}
                    !== 7'b1_11_0_0_0_1) begin
                    errors++;
                    $display("FAIL bltu_exec: got %b want 1110001",
                             {branch, op_ula, sign, store_en, load_en,
                              pc_en});
                end
            end
            tick();
        end
        exp_ret++;
    endtask

    task automatic test_illegal();
        instrucao = 32'h0;
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (halted !== 1'b1 || illegal !== 1'b1 || busy !== 1'b0 ||
                pc_en !== 1'b0 || retired_count !== exp_ret[CW-1:0]) begin
                errors++;
                $display("FAIL halt_illegal_c%0d: got h%b i%b b%b p%b r%0d want 1 1 0 0 %0d",
                         c, halted, illegal, busy, pc_en, retired_count,
                         exp_ret[CW-1:0]);
            end
            start = ~start;
            instrucao = $urandom;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        go();
        instrucao = I_ADD;
        tick();
        tick();
        tick();
        checks++;
        if (retired_count !== CW'(1)) begin
            errors++;
            $display("FAIL pre_store_retired: got %0d want 1", retired_count);
        end
        instrucao = I_SD;
        for (int c = 0; c < 2 + MW; c++) begin
            checks++;
            if (obs !== exp_vec(I_SD, c)) begin
                errors++;
                $display("FAIL store_cyc%0d: got %h want %h", c, obs,
                         exp_vec(I_SD, c));
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (store_en !== 1'b0 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL store_reset_commit: got st%b pc%b want 0 0",
                     store_en, pc_en);
        end
        tick();
        reset = 1'b0;
        #1;
        exp_ret = 0;
        checks++;
        if (obs !== obs_t'(0) || retired_count !== '0) begin
            errors++;
            $display("FAIL store_reset_idle: got %h r%0d want 0000 r0",
                     obs, retired_count);
        end
    endtask

    task automatic test_wrap();
        go();
        for (int n = 0; n < 17; n++) begin
            instrucao = I_ADDI;
            tick();
            tick();
            checks++;
            if (obs !== exp_vec(I_ADDI, 2)) begin
                errors++;
                $display("FAIL addi%0d_exec: got %h want %h", n, obs,
                         exp_vec(I_ADDI, 2));
            end
            tick();
            exp_ret++;
        end
        checks++;
        if (retired_count !== CW'(1)) begin
            errors++;
            $display("FAIL wrap: got %0d want 1", retired_count);
        end
        instrucao = I_ECALL;
        tick();
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 ||
            retired_count !== CW'(1)) begin
            errors++;
            $display("FAIL ecall_halt: got h%b i%b r%0d want 1 0 1",
                     halted, illegal, retired_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] ir;
        int          k;
        int          last;
        go();
        for (int n = 0; n < 80; n++) begin
            ir = rand_instr();
            instrucao = ir;
            k = kind_of(ir);
            last = (k >= 2) ? 5 : len_of(ir) - 1;
            for (int c = 0; c <= last; c++) begin
                checks++;
                if (obs !== exp_vec(ir, c) ||
                    retired_count !== exp_ret[CW-1:0]) begin
                    errors++;
                    $display("FAIL rnd%0d_cyc%0d ir=%h: got %h r%0d want %h r%0d",
                             n, c, ir, obs, retired_count, exp_vec(ir, c),
                             exp_ret[CW-1:0]);
                end
                if (k < 2 && c == last) exp_ret++;
                if (c > 0) begin
                    instrucao = $urandom;
                    start = 1'($urandom_range(0, 1));
                end
                tick();
            end
            if (k >= 2) go();
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instrucao = '0;
        test_reset();
        test_add();
        test_load();
        test_bltu();
        test_illegal();
        test_reset_mid_store();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
